// File: rtl/conv_pkg.sv
// Shared types for the convolution window driver and the kernel compute engine.
package conv_pkg;

  localparam int unsigned MaxKernel = 3;

  typedef logic [7:0] pixel_t;

  typedef enum logic [2:0] {
    FILL,
    LAUNCH,
    WAIT_CLR,
    CLEARING,
    EMIT
  } drv_state_t;

  // Row-major: window[i][j] is row i, column j of the kernel footprint.
  typedef pixel_t [MaxKernel-1:0][MaxKernel-1:0] window_t;

endpackage

// File: rtl/conv_line_buffer.sv
// Holds the last MAX_KERNEL-1 image rows; row 0 is the oldest, row MAX_KERNEL-2 the newest.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned MAX_KERNEL = 3,
  parameter int unsigned IMG_W      = 640
) (
  input  logic                           clk_i,
  input  logic                           n_rst_i,
  input  logic                           wr_en_i,
  input  logic [$clog2(IMG_W)-1:0]       col_i,
  input  pixel_t                         pixel_i,
  output pixel_t [MAX_KERNEL-2:0]        col_o
);

  pixel_t mem_q [MAX_KERNEL-1][IMG_W];

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      for (int unsigned r = 0; r < MAX_KERNEL - 1; r++) begin
        for (int unsigned c = 0; c < IMG_W; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (wr_en_i) begin
      // Column slides up one row: the oldest pixel drops out, the new one enters as newest.
      for (int unsigned r = 0; r + 2 < MAX_KERNEL; r++) begin
        mem_q[r][col_i] <= mem_q[r+1][col_i];
      end
      mem_q[MAX_KERNEL-2][col_i] <= pixel_i;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < MAX_KERNEL - 1; r++) begin
      col_o[r] = mem_q[r][col_i];
    end
  end

endmodule

// File: rtl/conv_window_driver.sv
// Streams raster pixels into a sliding window and runs the start/clear/done handshake
// with the compute engine once per complete window.
module conv_window_driver
  import conv_pkg::*;
#(
  parameter int unsigned MAX_KERNEL = 3,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  in_valid,
  input  pixel_t                                in_pixel,
  output logic                                  in_ready,
  output pixel_t [MAX_KERNEL-1:0][MAX_KERNEL-1:0] window,
  output logic                                  start,
  input  logic                                  clear_signal,
  output logic                                  clear,
  input  logic                                  done,
  input  pixel_t                                blurred_pixel,
  output logic                                  out_valid,
  output pixel_t                                out_pixel,
  output logic [$clog2(IMG_W)-1:0]              out_x,
  output logic [$clog2(IMG_H)-1:0]              out_y,
  output logic                                  frame_done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  drv_state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  pixel_t [MAX_KERNEL-1:0][MAX_KERNEL-1:0] window_q, window_d;
  pixel_t [MAX_KERNEL-2:0] lb_col;

  logic          in_ready_q, in_ready_d;
  logic          start_q, start_d;
  logic          clear_q, clear_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          last_q, last_d;
  pixel_t        out_pixel_q, out_pixel_d;
  logic [XW-1:0] out_x_q, out_x_d;
  logic [YW-1:0] out_y_q, out_y_d;

  logic transfer, x_last, y_last, win_done;

  assign transfer = in_valid && in_ready_q;
  assign x_last   = (x_q == XW'(IMG_W - 1));
  assign y_last   = (y_q == YW'(IMG_H - 1));
  assign win_done = transfer && (x_q >= XW'(MAX_KERNEL - 1)) && (y_q >= YW'(MAX_KERNEL - 1));

  conv_line_buffer #(
    .MAX_KERNEL (MAX_KERNEL),
    .IMG_W      (IMG_W)
  ) u_line_buffer (
    .clk_i   (clk),
    .n_rst_i (n_rst),
    .wr_en_i (transfer),
    .col_i   (x_q),
    .pixel_i (in_pixel),
    .col_o   (lb_col)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    window_d    = window_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_pixel_d = out_pixel_q;
    last_d      = last_q;

    if (transfer) begin
      x_d = x_last ? '0 : x_q + 1'b1;
      if (x_last) begin
        y_d = y_last ? '0 : y_q + 1'b1;
      end
      for (int unsigned i = 0; i < MAX_KERNEL; i++) begin
        for (int unsigned j = 0; j + 1 < MAX_KERNEL; j++) begin
          window_d[i][j] = window_q[i][j+1];
        end
      end
      for (int unsigned i = 0; i + 1 < MAX_KERNEL; i++) begin
        window_d[i][MAX_KERNEL-1] = lb_col[i];
      end
      window_d[MAX_KERNEL-1][MAX_KERNEL-1] = in_pixel;
    end

    unique case (state_q)
      FILL: begin
        if (win_done) begin
          state_d = LAUNCH;
          out_x_d = x_q - XW'(MAX_KERNEL - 1);
          out_y_d = y_q - YW'(MAX_KERNEL - 1);
          last_d  = x_last && y_last;
        end
      end
      LAUNCH:   state_d = WAIT_CLR;
      WAIT_CLR: if (clear_signal) state_d = CLEARING;
      CLEARING: begin
        if (done) begin
          state_d     = EMIT;
          out_pixel_d = blurred_pixel;
        end
      end
      EMIT:     state_d = FILL;
      default:  state_d = FILL;
    endcase

    // Outputs are registered copies of the upcoming state's decode.
    in_ready_d   = (state_d == FILL);
    start_d      = (state_d == LAUNCH);
    clear_d      = (state_d == CLEARING);
    out_valid_d  = (state_d == EMIT);
    frame_done_d = (state_d == EMIT) && last_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= FILL;
      x_q          <= '0;
      y_q          <= '0;
      window_q     <= '0;
      in_ready_q   <= 1'b0;
      start_q      <= 1'b0;
      clear_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      last_q       <= 1'b0;
      out_pixel_q  <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      window_q     <= window_d;
      in_ready_q   <= in_ready_d;
      start_q      <= start_d;
      clear_q      <= clear_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      last_q       <= last_d;
      out_pixel_q  <= out_pixel_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign window     = window_q;
  assign start      = start_q;
  assign clear      = clear_q;
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_driver.sv
// Directed bench for conv_window_driver on a 4x4 image with a mock compute engine.
module tb_conv_window_driver;

  logic                 clk;
  logic                 n_rst;
  logic                 in_valid;
  logic [7:0]           in_pixel;
  logic                 in_ready;
  logic [2:0][2:0][7:0] window;
  logic                 start;
  logic                 clear_signal;
  logic                 clear;
  logic                 done;
  logic [7:0]           blurred_pixel;
  logic                 out_valid;
  logic [7:0]           out_pixel;
  logic [1:0]           out_x;
  logic [1:0]           out_y;
  logic                 frame_done;

  logic eng_en, eng_clr, eng_done, man_clr, man_done;
  int   checks;
  int   errors;

  assign clear_signal = eng_clr | man_clr;
  assign done         = eng_done | man_done;

  conv_window_driver #(
    .MAX_KERNEL (3),
    .IMG_W      (4),
    .IMG_H      (4)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .in_valid      (in_valid),
    .in_pixel      (in_pixel),
    .in_ready      (in_ready),
    .window        (window),
    .start         (start),
    .clear_signal  (clear_signal),
    .clear         (clear),
    .done          (done),
    .blurred_pixel (blurred_pixel),
    .out_valid     (out_valid),
    .out_pixel     (out_pixel),
    .out_x         (out_x),
    .out_y         (out_y),
    .frame_done    (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mock engine: clear_signal 3 cycles after start, done 2 cycles after that.
  initial begin
    eng_clr       = 1'b0;
    eng_done      = 1'b0;
    blurred_pixel = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (eng_en && start) begin
        repeat (3) @(posedge clk);
        #1 eng_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 eng_done = 1'b1;
        blurred_pixel = 8'h5A;
        @(posedge clk);
        #1 eng_done = 1'b0;
        eng_clr = 1'b0;
      end
    end
  end

  function automatic logic [71:0] win(input int b);
    logic [2:0][2:0][7:0] w;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[i][j] = 8'(b + i * 4 + j);
      end
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send(input int v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_pixel = 8'(v);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 72'(in_ready), 72'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_emit(input int ex, input int ey, input logic efd);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("emit_seen", 72'(out_valid), 72'd1);
    check("emit_x", 72'(out_x), 72'(ex));
    check("emit_y", 72'(out_y), 72'(ey));
    check("emit_pix", 72'(out_pixel), 72'h5A);
    check("emit_fd", 72'(frame_done), 72'(efd));
  endtask

  initial begin
    int idx, nout, nfd, cyc;
    int ex[4];
    int ey[4];
    ex = '{0, 1, 0, 1};
    ey = '{0, 0, 1, 1};
    checks   = 0;
    errors   = 0;
    n_rst    = 1'b0;
    in_valid = 1'b0;
    in_pixel = 8'h00;
    eng_en   = 1'b1;
    man_clr  = 1'b0;
    man_done = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 72'(in_ready), 72'd0);
    check("rst_start", 72'(start), 72'd0);
    check("rst_clear", 72'(clear), 72'd0);
    check("rst_oval", 72'(out_valid), 72'd0);
    check("rst_fd", 72'(frame_done), 72'd0);
    check("rst_opix", 72'(out_pixel), 72'd0);
    check("rst_ox", 72'(out_x), 72'd0);
    check("rst_oy", 72'(out_y), 72'd0);
    check("rst_window", window, 72'd0);
    n_rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 72'(in_ready), 72'd1);

    // Prime: 0..9 never launch, 10 launches
    for (int i = 0; i < 10; i++) begin
      send(i);
      check("prime_no_start", 72'(start), 72'd0);
    end
    send(10);
    check("first_start", 72'(start), 72'd1);
    check("first_window", window, win(0));
    check("busy_ready", 72'(in_ready), 72'd0);

    // Handshake timing relative to start cycle S
    repeat (3) @(negedge clk);
    check("hs_clear_pre", 72'(clear), 72'd0);
    @(negedge clk);
    check("hs_clear_rise", 72'(clear), 72'd1);
    check("hs_start_low", 72'(start), 72'd0);
    @(negedge clk);
    check("hs_clear_hold", 72'(clear), 72'd1);
    check("hs_oval_pre", 72'(out_valid), 72'd0);
    @(negedge clk);
    check("hs_oval", 72'(out_valid), 72'd1);
    check("hs_opix", 72'(out_pixel), 72'h5A);
    check("hs_ox", 72'(out_x), 72'd0);
    check("hs_oy", 72'(out_y), 72'd0);
    check("hs_clear_fall", 72'(clear), 72'd0);
    check("hs_fd", 72'(frame_done), 72'd0);
    check("hs_ready_emit", 72'(in_ready), 72'd0);
    check("hs_window_frozen", window, win(0));
    @(negedge clk);
    check("hs_ready_back", 72'(in_ready), 72'd1);
    check("hs_oval_drop", 72'(out_valid), 72'd0);

    // Row wrap: 11 launches, 12 and 13 do not, 14 and 15 do
    send(11);
    check("wrap11_start", 72'(start), 72'd1);
    check("wrap11_window", window, win(1));
    wait_emit(1, 0, 1'b0);
    send(12);
    check("wrap12_no_start", 72'(start), 72'd0);
    send(13);
    check("wrap13_no_start", 72'(start), 72'd0);
    send(14);
    check("wrap14_start", 72'(start), 72'd1);
    check("wrap14_window", window, win(4));
    wait_emit(0, 1, 1'b0);
    send(15);
    check("wrap15_start", 72'(start), 72'd1);
    wait_emit(1, 1, 1'b1);

    // Full frame with in_valid held high
    idx  = 0;
    nout = 0;
    nfd  = 0;
    cyc  = 0;
    while (!(nout == 4 && idx == 16) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (frame_done) nfd++;
      if (start) check("ff_busy_ready", 72'(in_ready), 72'd0);
      if (out_valid && nout < 4) begin
        check("ff_x", 72'(out_x), 72'(ex[nout]));
        check("ff_y", 72'(out_y), 72'(ey[nout]));
        check("ff_fd", 72'(frame_done), 72'(nout == 3));
        check("ff_window", window, win(ey[nout] * 4 + ex[nout]));
        check("ff_pix", 72'(out_pixel), 72'h5A);
        nout++;
      end
      if (idx == 16) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_pixel = 8'(idx);
        if (in_ready) idx++;
      end
    end
    in_valid = 1'b0;
    check("ff_count", 72'(nout), 72'd4);
    check("ff_accepted", 72'(idx), 72'd16);
    check("ff_fd_count", 72'(nfd), 72'd1);

    // Spurious done/clear_signal while filling
    @(negedge clk);
    @(negedge clk);
    man_clr  = 1'b1;
    man_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sp_oval", 72'(out_valid), 72'd0);
      check("sp_clear", 72'(clear), 72'd0);
      check("sp_start", 72'(start), 72'd0);
      check("sp_ready", 72'(in_ready), 72'd1);
    end
    man_clr  = 1'b0;
    man_done = 1'b0;

    // Reset during CLEARING with the mock engine parked
    eng_en = 1'b0;
    for (int i = 0; i < 10; i++) send(i);
    send(10);
    check("rc_start", 72'(start), 72'd1);
    man_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rc_clearing", 72'(clear), 72'd1);
    n_rst = 1'b0;
    #1;
    check("rc_clear_rst", 72'(clear), 72'd0);
    check("rc_start_rst", 72'(start), 72'd0);
    check("rc_oval_rst", 72'(out_valid), 72'd0);
    check("rc_ready_rst", 72'(in_ready), 72'd0);
    man_clr = 1'b0;
    @(negedge clk);
    n_rst  = 1'b1;
    eng_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(i);
      check("rc_no_start", 72'(start), 72'd0);
    end
    send(10);
    check("rc_restart", 72'(start), 72'd1);
    check("rc_window", window, win(0));
    wait_emit(0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_driver.md
# conv_window_driver

Initiator side of the convolution-engine start/clear/done handshake. Accepts a raster-order 8-bit pixel stream, keeps the last MAX_KERNEL-1 image rows in line buffers, and assembles each complete MAX_KERNEL×MAX_KERNEL window. For each window it presents the window to the kernel compute engine, pulses start, answers the engine's clear request and collects the result. Sits between the pixel source (frame reader) and the compute engine; its output feeds the result writer.

## Interface
- MAX_KERNEL, 3: window edge length; must match the engine.
- IMG_W, 640: image width in pixels, ≥ MAX_KERNEL.
- IMG_H, 480: image height in pixels, ≥ MAX_KERNEL.
- clk  in  1  clock; all logic on rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  source has a pixel on in_pixel.
- in_pixel  in  8  raster-order pixel.
- in_ready  out  1  driver accepts a pixel this cycle.
- window  out  [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]  to engine input_matrix.
- start  out  1  one-cycle launch pulse to engine.
- clear_signal  in  1  engine requests accumulator clear.
- clear  out  1  clear command to engine.
- done  in  1  engine finished; blurred_pixel valid this cycle.
- blurred_pixel  in  8  engine result.
- out_valid  out  1  one-cycle result strobe.
- out_pixel  out  8  result value.
- out_x  out  $clog2(IMG_W)  output column, x-(MAX_KERNEL-1).
- out_y  out  $clog2(IMG_H)  output row, y-(MAX_KERNEL-1).
- frame_done  out  1  pulses with the last result of a frame.

## Operation
- Transfer occurs when in_valid && in_ready; in_ready = 1 only in FILL.
- Counters x (0..IMG_W-1) and y (0..IMG_H-1) give the position of the pixel being accepted; x wraps to 0 and increments y; after (IMG_W-1, IMG_H-1) both wrap to 0.
- On each transfer, window shifts one column left. The new rightmost column is {line buffer oldest row..newest row, in_pixel}. window[i][j] = image(y-(MAX_KERNEL-1)+i, x-(MAX_KERNEL-1)+j). The pixel is also written into the line buffer at column x.
- A transfer with x ≥ MAX_KERNEL-1 and y ≥ MAX_KERNEL-1 completes a window and moves the FSM to LAUNCH. Any other transfer stays in FILL. Windows never straddle a row wrap, because x < MAX_KERNEL-1 never launches.
- FSM states:
  - FILL: accept pixels.
  - LAUNCH: start=1 for one cycle, then go to WAIT_CLR.
  - WAIT_CLR: wait for clear_signal=1, then go to CLEARING.
  - CLEARING: clear=1. When done=1, capture blurred_pixel and go to EMIT.
  - EMIT: out_valid=1, then return to FILL.
- window is frozen from LAUNCH through EMIT.
- out_x/out_y are latched at launch. frame_done=1 in EMIT iff the launching pixel was (IMG_W-1, IMG_H-1).
- done or clear_signal outside its expected state is ignored. clear_signal dropping in CLEARING before done does not deassert clear.
- Output image is (IMG_W-MAX_KERNEL+1)×(IMG_H-MAX_KERNEL+1). No border padding.

## Timing
- Reset values: in_ready=0 (FSM=FILL, so in_ready goes to 1 in the first cycle after reset release), start=0, clear=0, out_valid=0, frame_done=0, out_pixel=0, out_x=0, out_y=0, window=0. Counters and line buffers are zero. A reset mid-handshake returns to FILL immediately; the partial frame is discarded.
- Completing transfer in cycle N gives start=1 in N+1. in_ready=0 from N+1 until EMIT ends.
- clear rises in the cycle after clear_signal is first seen. It falls in the cycle after done (EMIT).
- done in cycle D gives out_valid=1 with out_pixel=blurred_pixel in D+1. in_ready=1 in D+2.
- start is separated by ≥ 3 low cycles between launches, which satisfies the engine's edge detector.
- All outputs are registered. Per-window overhead is 4 cycles plus engine latency.

## Structure
- Package conv_pkg holds:
  - pixel_t (logic [7:0]).
  - drv_state_t enum {FILL, LAUNCH, WAIT_CLR, CLEARING, EMIT}.
  - The window type, shared with the compute engine.
- Sub-module conv_line_buffer #(MAX_KERNEL, IMG_W):
  - MAX_KERNEL-1 rows × IMG_W bytes.
  - Combinational read of column x across all rows.
  - Write on transfer that shifts column x upward (oldest row drops).
- Driver FSM, counters and window register live in the top module.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, MAX_KERNEL=3, pixel value = raster index, and a mock engine that raises clear_signal 3 cycles after start, then done 2 cycles later with blurred_pixel=0x5A.
- Prime: stream indices 0..9 → no start pulse. Index 10 → start in next cycle, window={{0,1,2},{4,5,6},{8,9,10}}.
- Handshake: first window → clear rises the cycle after clear_signal. out_valid=1, out_pixel=0x5A, out_x=0, out_y=0 the cycle after done. clear=0 in that same cycle.
- Full frame: 16 pixels with in_valid held high → exactly 4 out_valid at (0,0),(1,0),(0,1),(1,1). frame_done only with (1,1). in_ready=0 while busy, no pixel lost or duplicated.
- Row wrap: indices 11 and 12 → 11 launches, 12 (x=0) does not. Index 14 window={{4,5,6},{8,9,10},{12,13,14}}.
- Spurious inputs: done=1 and clear_signal=1 during FILL → no state change, no out_valid.
- Reset mid-CLEARING: n_rst low → clear=0, start=0, out_valid=0 immediately. After release, indices 0..10 of a new frame give first window {{0,1,2},{4,5,6},{8,9,10}}.
